// File: rtl/video_timing_pkg.sv
// Shared PAL raster geometry, counter widths and a modulo window compare
// used by the pal_video_timing block.
package video_timing_pkg;

    localparam int unsigned PAL_H_TOTAL       = 912;
    localparam int unsigned PAL_V_TOTAL       = 312;
    localparam int unsigned PAL_H_SYNC_START  = 704;
    localparam int unsigned PAL_H_SYNC_LEN    = 64;
    localparam int unsigned PAL_V_BLANK_START = 248;
    localparam int unsigned PAL_V_SYNC_LEN    = 4;
    localparam int unsigned PAL_H_BLANK_START = 640;
    localparam int unsigned PAL_INT_LEN       = 128;

    localparam int unsigned HC_W = 10;
    localparam int unsigned VC_W = 9;

    // Fixed Spectrum paper area and blanking tails
    localparam int unsigned PAPER_H       = 512;
    localparam int unsigned PAPER_V       = 192;
    localparam int unsigned H_BLANK_TAIL  = 80;
    localparam int unsigned V_BLANK_LINES = 8;

    // True when x lies in [start, start+len) taken modulo total
    function automatic logic in_window(input int unsigned x, input int unsigned start,
                                       input int unsigned len, input int unsigned total);
        int unsigned off;
        off = (x + total - (start % total)) % total;
        return off < len;
    endfunction

endpackage

// File: rtl/pal_video_timing_if.sv
// Pixel-enable input and timing outputs of the PAL raster generator.
interface pal_video_timing_if;
    import video_timing_pkg::*;

    logic            clk14en;
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            hsync_ext_n;
    logic            vsync_ext_n;
    logic            csync_ext_n;
    logic            hblank;
    logic            vblank;
    logic            paper;
    logic            int_n;
    logic            line_start;
    logic            frame_start;

    modport master (
        input  clk14en,
        output hc, vc, hsync_ext_n, vsync_ext_n, csync_ext_n,
        output hblank, vblank, paper, int_n, line_start, frame_start
    );

    modport slave (
        output clk14en,
        input  hc, vc, hsync_ext_n, vsync_ext_n, csync_ext_n,
        input  hblank, vblank, paper, int_n, line_start, frame_start
    );

endinterface

// File: rtl/hv_counter.sv
// Enable-qualified horizontal/vertical wrap counters; also exposes the
// next-state values so decoded flags can be registered without skew.
module hv_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL = PAL_H_TOTAL,
    parameter int unsigned V_TOTAL = PAL_V_TOTAL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic [HC_W-1:0] hc_next_c,
    output logic [VC_W-1:0] vc_next_c
);

    always_comb begin
        hc_next_c = hc;
        vc_next_c = vc;
        if (en) begin
            if (hc == HC_W'(H_TOTAL - 1)) begin
                hc_next_c = '0;
                vc_next_c = (vc == VC_W'(V_TOTAL - 1)) ? '0 : vc + VC_W'(1);
            end else begin
                hc_next_c = hc + HC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else begin
            hc <= hc_next_c;
            vc <= vc_next_c;
        end
    end

endmodule

// File: rtl/pal_video_timing.sv
// 50 Hz PAL raster timing for the Spectrum video path. Define
// PAL_CSYNC_SERRATION_EN to add two serration windows per VSYNC line on csync.
module pal_video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL       = PAL_H_TOTAL,
    parameter int unsigned H_BLANK_START = PAL_H_BLANK_START,
    parameter int unsigned H_SYNC_START  = PAL_H_SYNC_START,
    parameter int unsigned H_SYNC_LEN    = PAL_H_SYNC_LEN,
    parameter int unsigned V_TOTAL       = PAL_V_TOTAL,
    parameter int unsigned V_BLANK_START = PAL_V_BLANK_START,
    parameter int unsigned V_SYNC_LEN    = PAL_V_SYNC_LEN,
    parameter int unsigned INT_LEN       = PAL_INT_LEN
) (
    input  logic                clk,
    input  logic                rst,
    pal_video_timing_if.master  vid
);

    localparam int unsigned HB_END = H_TOTAL - H_BLANK_TAIL;
    localparam int unsigned HS_END = H_SYNC_START + H_SYNC_LEN;
    localparam int unsigned VB_END = V_BLANK_START + V_BLANK_LINES;
    localparam int unsigned VS_END = V_BLANK_START + V_SYNC_LEN;

    // Geometry must fit the counters and keep every window ordered
    if (H_TOTAL > (2 ** HC_W) || V_TOTAL > (2 ** VC_W) || H_TOTAL < H_BLANK_TAIL ||
        HS_END > H_TOTAL || H_BLANK_START >= HB_END || VB_END > V_TOTAL ||
        V_SYNC_LEN > V_BLANK_LINES || INT_LEN > H_TOTAL) begin : g_bad_geometry
        $error("pal_video_timing: parameter sums exceed counter range");
    end

    logic [HC_W-1:0] hc_next_c;
    logic [VC_W-1:0] vc_next_c;

    hv_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_hv_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (vid.clk14en),
        .hc        (vid.hc),
        .vc        (vid.vc),
        .hc_next_c (hc_next_c),
        .vc_next_c (vc_next_c)
    );

    logic hsync_n_c, vsync_n_c, csync_n_c;
    logic hblank_c, vblank_c, paper_c, int_n_c;
    logic line_start_c, frame_start_c;

`ifdef PAL_CSYNC_SERRATION_EN
    localparam int unsigned SER2_START = (H_SYNC_START + H_TOTAL / 2) % H_TOTAL;
`endif

    // Decode from next counter values so registered flags align with hc/vc
    always_comb begin
        hsync_n_c     = !(hc_next_c >= HC_W'(H_SYNC_START) && hc_next_c < HC_W'(HS_END));
        vsync_n_c     = !(vc_next_c >= VC_W'(V_BLANK_START) && vc_next_c < VC_W'(VS_END));
        hblank_c      = hc_next_c >= HC_W'(H_BLANK_START) && hc_next_c < HC_W'(HB_END);
        vblank_c      = vc_next_c >= VC_W'(V_BLANK_START) && vc_next_c < VC_W'(VB_END);
        paper_c       = hc_next_c < HC_W'(PAPER_H) && vc_next_c < VC_W'(PAPER_V);
        int_n_c       = !(vc_next_c == VC_W'(V_BLANK_START) && hc_next_c < HC_W'(INT_LEN));
        line_start_c  = vid.clk14en && (hc_next_c == '0);
        frame_start_c = line_start_c && (vc_next_c == '0);
`ifdef PAL_CSYNC_SERRATION_EN
        csync_n_c     = hsync_n_c;
        if (!vsync_n_c) begin
            csync_n_c = in_window(32'(hc_next_c), H_SYNC_START, H_SYNC_LEN, H_TOTAL) ||
                        in_window(32'(hc_next_c), SER2_START, H_SYNC_LEN, H_TOTAL);
        end
`else
        csync_n_c     = hsync_n_c & vsync_n_c;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid.hsync_ext_n <= 1'b1;
            vid.vsync_ext_n <= 1'b1;
            vid.csync_ext_n <= 1'b1;
            vid.hblank      <= 1'b0;
            vid.vblank      <= 1'b0;
            vid.paper       <= 1'b1;
            vid.int_n       <= 1'b1;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.hsync_ext_n <= hsync_n_c;
            vid.vsync_ext_n <= vsync_n_c;
            vid.csync_ext_n <= csync_n_c;
            vid.hblank      <= hblank_c;
            vid.vblank      <= vblank_c;
            vid.paper       <= paper_c;
            vid.int_n       <= int_n_c;
            vid.line_start  <= line_start_c;
            vid.frame_start <= frame_start_c;
        end
    end

endmodule
